// File: rtl/load_store_unit_if.sv
// Core-side request/response and data_mem-side port bundle of the load/store unit.
interface load_store_unit_if #(
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DWIDTH = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DWIDTH-1:0] resp_rdata;
  logic              resp_err;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_wen;
  logic [3:0]        mem_wmask;
  logic [DWIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wen, mem_wmask
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wen, mem_wmask
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: checks alignment and range, performs a one-cycle
// data_mem access, and returns a registered, extended response.
module load_store_unit #(
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DWIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave lsu_bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  state_e            r_state, w_state_d;
  logic              r_we, w_we_d;
  logic [1:0]        r_size, w_size_d;
  logic              r_unsigned, w_unsigned_d;
  logic [AWIDTH-1:0] r_addr, w_addr_d;
  logic [DWIDTH-1:0] r_wdata, w_wdata_d;
  logic [DWIDTH-1:0] r_rdata, w_rdata_d;
  logic              r_err, w_err_d;

  logic [AWIDTH:0]   w_nbytes;
  logic [AWIDTH:0]   w_end;
  logic              w_req_err;
  logic [3:0]        w_req_lanes;
  logic [3:0]        w_lanes;
  logic [DWIDTH-1:0] w_req_wdata;
  logic [DWIDTH-1:0] w_load_data;

  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  always_comb begin
    case (lsu_bus.req_size)
      2'b00:   w_nbytes = (AWIDTH+1)'(1);
      2'b01:   w_nbytes = (AWIDTH+1)'(2);
      default: w_nbytes = (AWIDTH+1)'(4);
    endcase
  end

  // One extra bit so the end address can be compared against 2**AWIDTH without wrapping.
  assign w_end = {1'b0, lsu_bus.req_addr} + w_nbytes;

  assign w_req_err = (lsu_bus.req_size == 2'b11) ||
                     ((lsu_bus.req_size == 2'b01) && lsu_bus.req_addr[0]) ||
                     ((lsu_bus.req_size == 2'b10) && (lsu_bus.req_addr[1:0] != 2'b00)) ||
                     (w_end > {1'b1, {AWIDTH{1'b0}}});

  assign w_req_lanes = lane_mask(lsu_bus.req_size);
  assign w_lanes     = lane_mask(r_size);
  assign w_req_wdata = lsu_bus.req_wdata & {{8{w_req_lanes[3]}}, {8{w_req_lanes[2]}},
                                            {8{w_req_lanes[1]}}, {8{w_req_lanes[0]}}};

  always_comb begin
    case (r_size)
      2'b00:   w_load_data = {{(DWIDTH-8){~r_unsigned & lsu_bus.mem_rdata[7]}},
                              lsu_bus.mem_rdata[7:0]};
      2'b01:   w_load_data = {{(DWIDTH-16){~r_unsigned & lsu_bus.mem_rdata[15]}},
                              lsu_bus.mem_rdata[15:0]};
      default: w_load_data = lsu_bus.mem_rdata;
    endcase
  end

  always_comb begin
    w_state_d    = r_state;
    w_we_d       = r_we;
    w_size_d     = r_size;
    w_unsigned_d = r_unsigned;
    w_addr_d     = r_addr;
    w_wdata_d    = r_wdata;
    w_rdata_d    = r_rdata;
    w_err_d      = r_err;
    unique case (r_state)
      StIdle: begin
        if (lsu_bus.req_valid) begin
          w_we_d       = lsu_bus.req_we;
          w_size_d     = lsu_bus.req_size;
          w_unsigned_d = lsu_bus.req_unsigned;
          w_addr_d     = lsu_bus.req_addr;
          w_wdata_d    = w_req_wdata;
          if (w_req_err) begin
            w_err_d   = 1'b1;
            w_rdata_d = '0;
            w_state_d = StResp;
          end else begin
            w_state_d = StAccess;
          end
        end
      end
      StAccess: begin
        w_err_d   = 1'b0;
        w_rdata_d = r_we ? '0 : w_load_data;
        w_state_d = StResp;
      end
      StResp: begin
        if (lsu_bus.resp_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_we       <= w_we_d;
      r_size     <= w_size_d;
      r_unsigned <= w_unsigned_d;
      r_addr     <= w_addr_d;
      r_wdata    <= w_wdata_d;
      r_rdata    <= w_rdata_d;
      r_err      <= w_err_d;
    end
  end

  assign lsu_bus.req_ready  = (r_state == StIdle);
  assign lsu_bus.resp_valid = (r_state == StResp);
  assign lsu_bus.resp_rdata = r_rdata;
  assign lsu_bus.resp_err   = r_err;
  assign lsu_bus.mem_addr   = r_addr;
  assign lsu_bus.mem_wdata  = r_wdata;
  assign lsu_bus.mem_wen    = (r_state == StAccess) && r_we;
  assign lsu_bus.mem_wmask  = lsu_bus.mem_wen ? w_lanes : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array data_mem stand-in, a transaction-level reference
// model checked every cycle, and directed transactions with literal expectations.
module tb_load_store_unit;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int passes = 0;

  load_store_unit_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  load_store_unit #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .lsu_bus (bus)
  );

  always #5 clk = ~clk;

  // data_mem stand-in: combinational read, masked write on clk, cleared by reset.
  logic [7:0] tb_mem [256];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 8'h00;
    end else if (bus.mem_wen) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_wmask[i]) tb_mem[bus.mem_addr + 8'(i)] <= bus.mem_wdata[8*i +: 8];
    end
  end
  assign bus.mem_rdata = {tb_mem[bus.mem_addr + 8'd3], tb_mem[bus.mem_addr + 8'd2],
                          tb_mem[bus.mem_addr + 8'd1], tb_mem[bus.mem_addr]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b, required %b", name, act, exp);
  endtask

  // Reference model: what one outstanding transaction must look like, cycle by cycle.
  logic [7:0]  ref_mem [256];
  bit          m_ready = 1'b1;
  bit          m_valid = 1'b0;
  bit          m_slot  = 1'b0;
  bit          m_err   = 1'b0;
  bit          m_we    = 1'b0;
  bit          m_uns   = 1'b0;
  logic [1:0]  m_size  = 2'b00;
  logic [7:0]  m_addr  = 8'h00;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] m_rdata = 32'h0;

  function automatic logic [31:0] m_load(input logic [1:0] size, input bit uns,
                                         input logic [7:0] addr);
    int n = 1 << size;
    longint v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[addr + 8'(i)]) << (8 * i));
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic bit m_is_err(input logic [1:0] size, input logic [7:0] addr);
    int n = 1 << size;
    return (size == 2'b11) || ((int'(addr) % n) != 0) || (int'(addr) + n > (1 << AW));
  endfunction

  initial begin
    int n;
    logic [3:0] exp_mask;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ready = 1'b1; m_valid = 1'b0; m_slot = 1'b0; m_err = 1'b0;
        m_we = 1'b0; m_uns = 1'b0; m_size = 2'b00; m_addr = 8'h00;
        m_wdata = 32'h0; m_rdata = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        chkb("rst_req_ready", bus.req_ready, 1'b1);
        chkb("rst_resp_valid", bus.resp_valid, 1'b0);
        chkb("rst_resp_err", bus.resp_err, 1'b0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chkb("rst_mem_wen", bus.mem_wen, 1'b0);
        chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      end else begin
        n = 1 << m_size;
        exp_mask = (m_slot && m_we) ? 4'((1 << n) - 1) : 4'b0000;
        chkb("req_ready", bus.req_ready, m_ready);
        chkb("resp_valid", bus.resp_valid, m_valid);
        chkb("mem_wen", bus.mem_wen, m_slot && m_we);
        chk("mem_wmask", 32'(bus.mem_wmask), 32'(exp_mask));
        chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        if (m_valid) begin
          chk("resp_rdata", bus.resp_rdata, m_rdata);
          chkb("resp_err", bus.resp_err, m_err);
        end
        if (m_slot && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
        // Predict the state after the coming clock edge.
        if (m_slot) begin
          if (m_we) for (int i = 0; i < n; i++) ref_mem[m_addr + 8'(i)] = m_wdata[8*i +: 8];
          m_rdata = m_we ? 32'h0 : m_load(m_size, m_uns, m_addr);
          m_err   = 1'b0;
          m_slot  = 1'b0;
          m_valid = 1'b1;
        end else if (m_valid) begin
          if (bus.resp_ready) begin
            m_valid = 1'b0;
            m_ready = 1'b1;
          end
        end else if (m_ready && bus.req_valid) begin
          m_we    = bus.req_we;
          m_size  = bus.req_size;
          m_uns   = bus.req_unsigned;
          m_addr  = bus.req_addr;
          n       = 1 << bus.req_size;
          m_wdata = bus.req_wdata & 32'((64'd1 << (8 * n)) - 64'd1);
          m_ready = 1'b0;
          if (m_is_err(bus.req_size, bus.req_addr)) begin
            m_valid = 1'b1;
            m_err   = 1'b1;
            m_rdata = 32'h0;
          end else begin
            m_slot = 1'b1;
          end
        end
      end
    end
  end

  // Results of the last transaction, as seen by the driver.
  logic [31:0] cap_rdata;
  logic        cap_err;
  int          cap_lat;
  int          cap_acc;
  logic        cap_wen;
  logic [3:0]  cap_mask;
  logic [31:0] cap_wdata;

  // Inputs change only at posedge+1 so the model sees them settled at the negedge.
  task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        input int hold, input bit bp, input logic [31:0] hold_exp);
    bit ok;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    cap_acc = 0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      cap_acc++;
      if (bus.req_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    chkb("accept_seen", ok, 1'b1);
    bus.req_valid = 1'b0;
    cap_lat = 0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      cap_lat++;
      if (cap_lat == 1) begin
        cap_wen   = bus.mem_wen;
        cap_mask  = bus.mem_wmask;
        cap_wdata = bus.mem_wdata;
      end
      if (bus.resp_valid) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chkb("resp_seen", ok, 1'b1);
    cap_rdata = bus.resp_rdata;
    cap_err   = bus.resp_err;
    if (bp) begin
      bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
      bus.req_addr = 8'h40; bus.req_wdata = 32'h55AA55AA; bus.req_valid = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chkb("hold_resp_valid", bus.resp_valid, 1'b1);
      chk("hold_resp_rdata", bus.resp_rdata, hold_exp);
      chkb("hold_req_ready", bus.req_ready, 1'b0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic expect_ok(input string name, input logic [31:0] rdata);
    chk({name, "_rdata"}, cap_rdata, rdata);
    chkb({name, "_err"}, cap_err, 1'b0);
    chk({name, "_lat"}, cap_lat, 2);
  endtask

  task automatic expect_err(input string name);
    chk({name, "_rdata"}, cap_rdata, 32'h0);
    chkb({name, "_err"}, cap_err, 1'b1);
    chk({name, "_lat"}, cap_lat, 1);
    chkb({name, "_wen"}, cap_wen, 1'b0);
  endtask

  initial begin
    int mism;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 8'h00; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chkb("reset_req_ready", bus.req_ready, 1'b1);
    chkb("reset_resp_valid", bus.resp_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then load.
    do_req(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0);
    expect_ok("sw_10", 32'h0);
    chkb("sw_10_wen", cap_wen, 1'b1);
    chk("sw_10_mask", 32'(cap_mask), 32'hF);
    chk("sw_10_wdata", cap_wdata, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 0, 1'b0, 32'h0);
    expect_ok("lw_10", 32'hDEADBEEF);
    chkb("lw_10_wen", cap_wen, 1'b0);

    // Byte/half extension.
    do_req(1'b1, 2'b00, 1'b0, 8'h20, 32'h00000080, 0, 1'b0, 32'h0);
    do_req(1'b1, 2'b00, 1'b0, 8'h21, 32'h000000FF, 0, 1'b0, 32'h0);
    chk("sb_21_mask", 32'(cap_mask), 32'h1);
    do_req(1'b0, 2'b00, 1'b0, 8'h20, 32'h0, 0, 1'b0, 32'h0);
    expect_ok("lb_20", 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 8'h20, 32'h0, 0, 1'b0, 32'h0);
    expect_ok("lbu_20", 32'h00000080);
    do_req(1'b0, 2'b01, 1'b0, 8'h20, 32'h0, 0, 1'b0, 32'h0);
    expect_ok("lh_20", 32'hFFFFFF80);
    do_req(1'b0, 2'b01, 1'b1, 8'h20, 32'h0, 0, 1'b0, 32'h0);
    expect_ok("lhu_20", 32'h0000FF80);

    // Partial store into a word; upper store-data lanes must be forced to zero.
    do_req(1'b1, 2'b10, 1'b0, 8'h30, 32'h11223344, 0, 1'b0, 32'h0);
    do_req(1'b1, 2'b00, 1'b0, 8'h31, 32'hFFFFFFAA, 0, 1'b0, 32'h0);
    chk("sb_31_mask", 32'(cap_mask), 32'h1);
    chk("sb_31_wdata", cap_wdata, 32'h000000AA);
    do_req(1'b0, 2'b10, 1'b0, 8'h30, 32'h0, 0, 1'b0, 32'h0);
    expect_ok("lw_30", 32'h1122AA44);

    // Errors.
    do_req(1'b0, 2'b01, 1'b0, 8'h01, 32'h0, 0, 1'b0, 32'h0);
    expect_err("lh_01");
    do_req(1'b1, 2'b10, 1'b0, 8'h02, 32'hCAFEF00D, 0, 1'b0, 32'h0);
    expect_err("sw_02");
    do_req(1'b0, 2'b11, 1'b0, 8'h00, 32'h0, 0, 1'b0, 32'h0);
    expect_err("size_11");
    do_req(1'b0, 2'b10, 1'b0, 8'hFE, 32'h0, 0, 1'b0, 32'h0);
    expect_err("lw_fe");
    do_req(1'b0, 2'b10, 1'b0, 8'h00, 32'h0, 0, 1'b0, 32'h0);
    expect_ok("lw_00_after_err", 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 8'hFC, 32'h0, 0, 1'b0, 32'h0);
    expect_ok("lw_fc_top", 32'h0);

    // Backpressure with a competing request held on the bus.
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 5, 1'b1, 32'hDEADBEEF);
    expect_ok("lw_10_bp", 32'hDEADBEEF);
    do_req(1'b1, 2'b10, 1'b0, 8'h40, 32'h55AA55AA, 0, 1'b0, 32'h0);
    chk("bp_next_accept_wait", cap_acc, 1);
    do_req(1'b0, 2'b10, 1'b0, 8'h40, 32'h0, 0, 1'b0, 32'h0);
    expect_ok("lw_40", 32'h55AA55AA);

    // Reset while a store is in its memory-access cycle.
    bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.req_addr = 8'h50; bus.req_wdata = 32'h99999999; bus.req_valid = 1'b1;
    chkb("mid_pre_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chkb("mid_access_wen", bus.mem_wen, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chkb("mid_rst_wen", bus.mem_wen, 1'b0);
    chk("mid_rst_mask", 32'(bus.mem_wmask), 32'h0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 32'h0);
    chk("mid_rst_wdata", bus.mem_wdata, 32'h0);
    chkb("mid_rst_ready", bus.req_ready, 1'b1);
    chkb("mid_rst_valid", bus.resp_valid, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chkb("post_rst_ready", bus.req_ready, 1'b1);
    chkb("post_rst_valid", bus.resp_valid, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 8'h50, 32'h0, 0, 1'b0, 32'h0);
    expect_ok("lw_50_after_rst", 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 0, 1'b0, 32'h0);
    expect_ok("lw_10_after_rst", 32'h0);

    repeat (2) @(posedge clk);
    #1;
    mism = 0;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
    chk("mem_final_mismatches", 32'(mism), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
